prog_loader: RTL and testbench

Boot-time program loader for the single-cycle CPU: accepts a byte stream of load frames, assembles little-endian 32-bit words and writes them into instruction or data memory through a dedicated write port, then releases the CPU from reset.
- It is the write-side counterpart of the bench's state dump, which only reads PC, instruction, registers and memory.
- It sits between the host/bench byte source and the memories' back-door write ports.
- It drives the CPU's active-high run enable (`rst_i`).

---
 rtl/prog_loader.sv | 144 ++++++++++++++
 tb/tb_prog_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: parses framed byte stream, assembles LE 32-bit words,
// writes them to instruction/data memory, and finally releases the CPU.
module prog_loader #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    localparam logic [7:0] CMD_IM  = 8'hA0;
    localparam logic [7:0] CMD_DM  = 8'hA1;
    localparam logic [7:0] CMD_RUN = 8'hF0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR0,
        S_ADDR1,
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_t;

    state_t            state;
    logic [7:0]        addr_lo;
    logic [7:0]        cnt_lo;
    logic [15:0]       cnt;
    logic [15:0]       word_cnt;
    logic [1:0]        lane;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic [ADDR_W-1:0] waddr;

    logic        accept;
    logic [15:0] word_cnt_inc;
    logic [15:0] cnt_rx;

    assign accept       = in_valid && in_ready;
    assign word_cnt_inc = word_cnt + 16'd1;
    assign cnt_rx       = {in_data, cnt_lo};

    // Frame parser; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_lo   <= 8'd0;
            cnt_lo    <= 8'd0;
            cnt       <= 16'd0;
            word_cnt  <= 16'd0;
            lane      <= 2'd0;
            word_buf  <= 24'd0;
            csum      <= 8'd0;
            waddr     <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_run   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == CMD_IM || in_data == CMD_DM) begin
                            mem_sel <= in_data[0];
                            csum    <= 8'd0;
                            busy    <= 1'b1;
                            state   <= S_ADDR0;
                        end else if (in_data == CMD_RUN) begin
                            cpu_run  <= 1'b1;
                            in_ready <= 1'b0;
                            state    <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    S_ADDR0: begin
                        addr_lo <= in_data;
                        state   <= S_ADDR1;
                    end
                    S_ADDR1: begin
                        waddr <= ADDR_W'({in_data, addr_lo});
                        state <= S_CNT0;
                    end
                    S_CNT0: begin
                        cnt_lo <= in_data;
                        state  <= S_CNT1;
                    end
                    S_CNT1: begin
                        cnt      <= cnt_rx;
                        word_cnt <= 16'd0;
                        lane     <= 2'd0;
                        state    <= (cnt_rx == 16'd0) ? S_CSUM : S_DATA;
                    end
                    S_DATA: begin
                        csum <= csum ^ in_data;
                        lane <= lane + 2'd1;
                        // Bytes shift in from the top so lane 0 ends up least significant.
                        if (lane == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= waddr;
                            mem_wdata <= {in_data, word_buf};
                            waddr     <= waddr + ADDR_W'(1);
                            word_cnt  <= word_cnt_inc;
                            if (word_cnt_inc == cnt) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            word_buf <= {in_data, word_buf[23:8]};
                        end
                    end
                    S_CSUM: begin
                        if (in_data != csum) begin
                            err <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_RUN: begin
                        state <= S_RUN;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random byte gaps, frame-level reference model.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err)
    );

    typedef struct {bit sel; int unsigned addr; int unsigned data; int idx;} exp_t;
    typedef struct {bit sel; int unsigned addr; int unsigned data; int cyc;} obs_t;

    exp_t         exp_q[$];
    obs_t         wr_q[$];
    int           acc_q[$];
    byte unsigned stim[$];
    bit           m_err;
    bit           m_run;
    int           cyc;
    int           n_checks;
    int           n_fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_ready) acc_q.push_back(cyc);
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back('{mem_sel, 32'(mem_addr), mem_wdata, cyc});
    end

    function automatic void add_frame(input byte unsigned cmd, input int unsigned base,
                                      input int unsigned words[$], input bit bad);
        byte unsigned cs = 8'd0;
        byte unsigned bb;
        stim.push_back(cmd);
        stim.push_back(8'(base));
        stim.push_back(8'(base >> 8));
        stim.push_back(8'(words.size()));
        stim.push_back(8'(words.size() >> 8));
        foreach (words[k]) begin
            for (int j = 0; j < 4; j++) begin
                bb = 8'(words[k] >> (8 * j));
                cs = cs ^ bb;
                stim.push_back(bb);
            end
        end
        stim.push_back(bad ? (cs ^ 8'h01) : cs);
    endfunction

    // Frame-level reference: walks the byte list and lists the writes it implies.
    function automatic void model();
        int i = 0;
        while (i < stim.size()) begin
            byte unsigned cmd = stim[i];
            i++;
            if (m_run) break;
            if (cmd == 8'hA0 || cmd == 8'hA1) begin
                int unsigned base = 32'(stim[i]) | (32'(stim[i+1]) << 8);
                int unsigned cnt  = 32'(stim[i+2]) | (32'(stim[i+3]) << 8);
                byte unsigned cs  = 8'd0;
                i += 4;
                for (int unsigned k = 0; k < cnt; k++) begin
                    int unsigned w = 0;
                    for (int j = 0; j < 4; j++) begin
                        w  = w | (32'(stim[i+j]) << (8 * j));
                        cs = cs ^ stim[i+j];
                    end
                    exp_q.push_back('{cmd == 8'hA1, (base + k) % DEPTH, w, i + 3});
                    i += 4;
                end
                if (stim[i] != cs) m_err = 1'b1;
                i++;
            end else if (cmd == 8'hF0) begin
                m_run = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    task automatic drive();
        foreach (stim[i]) begin
            int t = 0;
            int gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            repeat (gap) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = stim[i];
            while (in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
            if (t >= 20) begin
                n_checks++; n_fails++;
                $display("FAIL drive_timeout byte %0d: in_ready=%b expected 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic play();
        exp_q.delete(); wr_q.delete(); acc_q.delete();
        model();
        drive();
        stim.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_err = 1'b0;
        m_run = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata, cpu_run, busy, err} !==
            {1'b1, 1'b0, 1'b0, ADDR_W'(0), 32'd0, 3'b000}) begin
            n_fails++;
            $display("FAIL reset_values: rdy=%b we=%b sel=%b addr=%h wd=%h run=%b busy=%b err=%b expected 1 0 0 0 0 0 0 0",
                     in_ready, mem_we, mem_sel, mem_addr, mem_wdata, cpu_run, busy, err);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        end
    endtask

    task automatic test_im_load();
        int unsigned w[$];
        w.push_back(32'h12345678); w.push_back(32'hDEADBEEF);
        add_frame(8'hA0, 0, w, 1'b0);
        play();
        n_checks++;
        if (wr_q.size() != 2 || wr_q[0].sel != 1'b0 || wr_q[0].addr != 0 || wr_q[0].data != 32'h12345678 ||
            wr_q[1].sel != 1'b0 || wr_q[1].addr != 1 || wr_q[1].data != 32'hDEADBEEF) begin
            n_fails++;
            $display("FAIL im_load_writes: got %0d writes (w0 %h@%0d) expected 2 (12345678@0, deadbeef@1)",
                     wr_q.size(), wr_q.size() > 0 ? wr_q[0].data : 0, wr_q.size() > 0 ? wr_q[0].addr : 0);
        end
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (wr_q[k].cyc != acc_q[exp_q[k].idx]) begin
                n_fails++;
                $display("FAIL im_load_timing word %0d: cycle %0d expected %0d", k, wr_q[k].cyc, acc_q[exp_q[k].idx]);
            end
        end
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL im_load_flags: err=%b busy=%b expected 0 0", err, busy);
        end
    endtask

    task automatic test_wrap();
        int unsigned w[$];
        w.push_back(32'd5); w.push_back(32'd6);
        add_frame(8'hA0, 16'h0FFF, w, 1'b0);
        play();
        n_checks++;
        if (wr_q.size() != 2 || wr_q[0].addr != 4095 || wr_q[0].data != 5 ||
            wr_q[1].addr != 0 || wr_q[1].data != 6) begin
            n_fails++;
            $display("FAIL wrap_writes: got %0d writes (first %0d@%0d) expected 5@4095, 6@0",
                     wr_q.size(), wr_q.size() > 0 ? wr_q[0].data : 0, wr_q.size() > 0 ? wr_q[0].addr : 0);
        end
        n_checks++;
        if (err !== m_err) begin
            n_fails++;
            $display("FAIL wrap_err: err=%b expected %b", err, m_err);
        end
    endtask

    task automatic test_cnt0_unknown();
        int unsigned w[$];
        add_frame(8'hA1, 0, w, 1'b0);
        play();
        n_checks++;
        if (wr_q.size() != 0 || err !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL cnt0: writes=%0d err=%b busy=%b expected 0 0 0", wr_q.size(), err, busy);
        end
        stim.push_back(8'h55);
        play();
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL unknown_cmd: err=%b busy=%b in_ready=%b expected 1 0 1", err, busy, in_ready);
        end
        w.push_back($urandom);
        add_frame(8'hA0, 16'h0123, w, 1'b0);
        play();
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0].addr != 32'h123 || wr_q[0].data != exp_q[0].data || err !== 1'b1) begin
            n_fails++;
            $display("FAIL after_unknown: writes=%0d err=%b expected 1 write at 0x123, err 1", wr_q.size(), err);
        end
    endtask

    task automatic test_dm_bad_csum();
        int unsigned w[$];
        w.push_back(32'd1);
        n_checks++;
        if (err !== 1'b0) begin
            n_fails++;
            $display("FAIL dm_pre_err: err=%b expected 0", err);
        end
        add_frame(8'hA1, 16'h0010, w, 1'b1);
        play();
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0].sel != 1'b1 || wr_q[0].addr != 16 || wr_q[0].data != 1) begin
            n_fails++;
            $display("FAIL dm_write: got %0d writes expected DM[16]=1", wr_q.size());
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fails++;
            $display("FAIL dm_bad_csum_err: err=%b expected 1", err);
        end
        w.delete(); w.push_back($urandom); w.push_back($urandom);
        add_frame(8'hA1, $urandom_range(0, 16'hFFFF), w, 1'b0);
        play();
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (wr_q[k].sel != exp_q[k].sel || wr_q[k].addr != exp_q[k].addr || wr_q[k].data != exp_q[k].data) begin
                n_fails++;
                $display("FAIL dm_good_word %0d: %0d:%h@%0d expected %0d:%h@%0d", k, wr_q[k].sel, wr_q[k].data,
                         wr_q[k].addr, exp_q[k].sel, exp_q[k].data, exp_q[k].addr);
            end
        end
        n_checks++;
        if (err !== 1'b1 || wr_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL dm_sticky: err=%b writes=%0d expected err 1 writes %0d", err, wr_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 8; f++) begin
            int unsigned w[$];
            if ($urandom_range(0, 9) == 0) begin
                stim.push_back(8'($urandom_range(0, 8'h9F)));
            end else begin
                int n = int'($urandom_range(0, 5));
                for (int k = 0; k < n; k++) w.push_back($urandom);
                add_frame($urandom_range(0, 1) ? 8'hA1 : 8'hA0,
                          (f == 3) ? 16'hFFFE : $urandom_range(0, 16'hFFFF), w, $urandom_range(0, 3) == 0);
            end
        end
        play();
        n_checks++;
        if (wr_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL b2b_count: writes=%0d expected %0d", wr_q.size(), exp_q.size());
        end
        for (int k = 0; k < wr_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (wr_q[k].sel != exp_q[k].sel || wr_q[k].addr != exp_q[k].addr ||
                wr_q[k].data != exp_q[k].data || wr_q[k].cyc != acc_q[exp_q[k].idx]) begin
                n_fails++;
                $display("FAIL b2b_word %0d: %0d:%h@%0d cyc %0d expected %0d:%h@%0d cyc %0d", k, wr_q[k].sel,
                         wr_q[k].data, wr_q[k].addr, wr_q[k].cyc, exp_q[k].sel, exp_q[k].data,
                         exp_q[k].addr, acc_q[exp_q[k].idx]);
            end
        end
        n_checks++;
        if (err !== m_err || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_flags: err=%b busy=%b expected %b 0", err, busy, m_err);
        end
    endtask

    task automatic test_reset_midframe();
        int unsigned w[$];
        exp_q.delete(); wr_q.delete(); acc_q.delete();
        stim = '{8'hA0, 8'h05, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
        drive();
        stim.delete();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++;
            $display("FAIL midframe_busy: busy=%b expected 1", busy);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata, cpu_run, busy, err} !==
            {1'b1, 1'b0, 1'b0, ADDR_W'(0), 32'd0, 3'b000} || wr_q.size() != 0) begin
            n_fails++;
            $display("FAIL midframe_reset: rdy=%b we=%b addr=%h wd=%h busy=%b err=%b writes=%0d expected reset values, 0 writes",
                     in_ready, mem_we, mem_addr, mem_wdata, busy, err, wr_q.size());
        end
        rst_n = 1'b1; m_err = 1'b0; m_run = 1'b0;
        w.push_back($urandom);
        add_frame(8'hA0, 16'h0005, w, 1'b0);
        play();
        n_checks++;
        if (wr_q.size() != 1 || wr_q[0].addr != 5 || wr_q[0].data != exp_q[0].data || err !== 1'b0) begin
            n_fails++;
            $display("FAIL midframe_fresh: writes=%0d err=%b expected 1 write %h@5, err 0",
                     wr_q.size(), err, exp_q[0].data);
        end
    endtask

    task automatic test_run();
        int n_acc;
        stim.push_back(8'hF0);
        play();
        n_checks++;
        if (cpu_run !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL run_enter: cpu_run=%b in_ready=%b busy=%b expected 1 0 0", cpu_run, in_ready, busy);
        end
        n_acc = acc_q.size();
        in_valid = 1'b1;
        repeat (10) begin in_data = 8'($urandom); @(posedge clk); #1; end
        in_valid = 1'b0;
        n_checks++;
        if (acc_q.size() != n_acc || wr_q.size() != 0 || cpu_run !== 1'b1) begin
            n_fails++;
            $display("FAIL run_ignore: accepted=%0d writes=%0d cpu_run=%b expected 0 0 1",
                     acc_q.size() - n_acc, wr_q.size(), cpu_run);
        end
        do_reset();
        n_checks++;
        if (cpu_run !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL run_reset: cpu_run=%b in_ready=%b expected 0 1", cpu_run, in_ready);
        end
    endtask

    initial begin
        n_checks = 0; n_fails = 0; cyc = 0; m_err = 1'b0; m_run = 1'b0;
        test_reset();
        test_im_load();
        test_wrap();
        test_cnt0_unknown();
        do_reset();
        test_dm_bad_csum();
        do_reset();
        test_back_to_back();
        do_reset();
        test_reset_midframe();
        test_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
